// File: rtl/dma_rd_burst_ctrl_if.sv
// Request/beat bus between the read-burst sequencer, the read DMA engine and
// the downstream beat consumer.
interface dma_rd_burst_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 256,
    parameter int LEN_W  = 8
);
    logic              dma_valid;
    logic [ADDR_W-1:0] dma_addr;
    logic [LEN_W-1:0]  dma_len;
    logic              dma_ready;
    logic [DATA_W-1:0] dma_rdata;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    modport master (
        output dma_valid, dma_addr, dma_len, out_valid, out_data, out_last,
        input  dma_ready, dma_rdata
    );

    modport slave (
        input  dma_valid, dma_addr, dma_len, out_valid, out_data, out_last,
        output dma_ready, dma_rdata
    );
endinterface

// File: rtl/dma_rd_burst_ctrl.sv
// Splits a (base, beat count) read job into back-to-back AXI INCR bursts and
// forwards returned beats as one stream. Define DMA_4K_BOUNDARY_EN to keep bursts inside 4 KB pages.
module dma_rd_burst_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 256,
    parameter int LEN_W  = 8,
    parameter int CNT_W  = 20
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic [ADDR_W-1:0]   base_addr_i,
    input  logic [CNT_W-1:0]    total_beats_i,
    input  logic [LEN_W-1:0]    cfg_max_len_i,
    output logic                busy_o,
    output logic                done_o,
    dma_rd_burst_ctrl_if.master bus
);
    localparam int BYTES = DATA_W / 8;
    localparam int SHIFT = $clog2(BYTES);
    localparam int BW    = LEN_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [CNT_W-1:0]  beats_left_q, beats_left_d;
    logic [LEN_W-1:0]  burst_cnt_q, burst_cnt_d;
    logic              dma_valid_q, dma_valid_d;
    logic [ADDR_W-1:0] dma_addr_q, dma_addr_d;
    logic [LEN_W-1:0]  dma_len_q, dma_len_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [BW-1:0]     cur_b_s;
    logic [BW-1:0]     first_b_s;
    logic [BW-1:0]     next_b_s;
    logic [CNT_W-1:0]  rem_s;
    logic [ADDR_W-1:0] next_addr_s;
    logic              last_beat_s;

    // Burst length in beats: min(beats left, max_len+1), kept one bit wider so 256 fits.
    function automatic logic [BW-1:0] burst_size(input logic [CNT_W-1:0] left,
                                                 input logic [LEN_W-1:0] max_len);
        logic [BW-1:0] cap;
        cap = {1'b0, max_len} + BW'(1);
        if (left < CNT_W'(cap)) begin
            burst_size = BW'(left);
        end else begin
            burst_size = cap;
        end
    endfunction

`ifdef DMA_4K_BOUNDARY_EN
    // Beats remaining before the next 4 KB page; addresses are beat-aligned so this is >= 1.
    function automatic logic [BW-1:0] clip_4k(input logic [BW-1:0] b,
                                              input logic [11:0]   page_off);
        logic [12:0] room;
        room = (13'd4096 - {1'b0, page_off}) >> SHIFT;
        if (32'(room) < 32'(b)) begin
            clip_4k = BW'(room);
        end else begin
            clip_4k = b;
        end
    endfunction
`endif

    assign cur_b_s     = {1'b0, dma_len_q} + BW'(1);
    assign rem_s       = beats_left_q - CNT_W'(cur_b_s);
    assign next_addr_s = cur_addr_q + (ADDR_W'(cur_b_s) << SHIFT);
    assign last_beat_s = (state_q == ST_RUN) && bus.dma_ready && (burst_cnt_q == dma_len_q);

`ifdef DMA_4K_BOUNDARY_EN
    assign first_b_s = clip_4k(burst_size(total_beats_i, cfg_max_len_i), base_addr_i[11:0]);
    assign next_b_s  = clip_4k(burst_size(rem_s, cfg_max_len_i), next_addr_s[11:0]);
`else
    assign first_b_s = burst_size(total_beats_i, cfg_max_len_i);
    assign next_b_s  = burst_size(rem_s, cfg_max_len_i);
`endif

    // Next-state and burst bookkeeping.
    always_comb begin
        state_d      = state_q;
        cur_addr_d   = cur_addr_q;
        beats_left_d = beats_left_q;
        burst_cnt_d  = burst_cnt_q;
        dma_valid_d  = dma_valid_q;
        dma_addr_d   = dma_addr_q;
        dma_len_d    = dma_len_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (total_beats_i != {CNT_W{1'b0}}) begin
                        state_d      = ST_RUN;
                        cur_addr_d   = base_addr_i;
                        beats_left_d = total_beats_i;
                        burst_cnt_d  = {LEN_W{1'b0}};
                        dma_valid_d  = 1'b1;
                        dma_addr_d   = base_addr_i;
                        dma_len_d    = LEN_W'(first_b_s - BW'(1));
                    end else begin
                        state_d = ST_FIN;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_beat_s) begin
                    burst_cnt_d  = {LEN_W{1'b0}};
                    beats_left_d = rem_s;
                    cur_addr_d   = next_addr_s;
                    // Chain the next request on the same edge so the engine sees no bubble.
                    if (rem_s != {CNT_W{1'b0}}) begin
                        dma_valid_d = 1'b1;
                        dma_addr_d  = next_addr_s;
                        dma_len_d   = LEN_W'(next_b_s - BW'(1));
                    end else begin
                        dma_valid_d = 1'b0;
                        state_d     = ST_FIN;
                    end
                end else if (bus.dma_ready) begin
                    burst_cnt_d = burst_cnt_q + LEN_W'(1);
                end else begin
                    burst_cnt_d = burst_cnt_q;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d     = ST_IDLE;
                dma_valid_d = 1'b0;
            end
        endcase
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_FIN);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cur_addr_q   <= {ADDR_W{1'b0}};
            beats_left_q <= {CNT_W{1'b0}};
            burst_cnt_q  <= {LEN_W{1'b0}};
            dma_valid_q  <= 1'b0;
            dma_addr_q   <= {ADDR_W{1'b0}};
            dma_len_q    <= {LEN_W{1'b0}};
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_addr_q   <= cur_addr_d;
            beats_left_q <= beats_left_d;
            burst_cnt_q  <= burst_cnt_d;
            dma_valid_q  <= dma_valid_d;
            dma_addr_q   <= dma_addr_d;
            dma_len_q    <= dma_len_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign bus.dma_valid = dma_valid_q;
    assign bus.dma_addr  = dma_addr_q;
    assign bus.dma_len   = dma_len_q;
    // Returned beats pass straight through; the consumer never stalls.
    assign bus.out_valid = (state_q == ST_RUN) && bus.dma_ready;
    assign bus.out_data  = bus.dma_rdata;
    assign bus.out_last  = last_beat_s && (rem_s == {CNT_W{1'b0}});
endmodule
